// File: rtl/prefetch_queue_if.sv
// Bus bundle for prefetch_queue: RAM read port, decode-side pop port and flush redirect.
// master = the prefetch queue, slave = the surrounding RAM/decode environment.
interface prefetch_queue_if #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DEPTH  = 6
);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic              flush;
  logic [ADDR_W-1:0] flush_addr;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ack;
  logic [7:0]        mem_rdata;
  logic              q_valid;
  logic [7:0]        q_byte;
  logic              q_pop;
  logic [CNT_W-1:0]  q_count;

  modport master (
    input  flush, flush_addr, mem_ack, mem_rdata, q_pop,
    output mem_req, mem_addr, q_valid, q_byte, q_count
  );

  modport slave (
    output flush, flush_addr, mem_ack, mem_rdata, q_pop,
    input  mem_req, mem_addr, q_valid, q_byte, q_count
  );
endinterface

// File: rtl/prefetch_queue.sv
// Byte-wide instruction prefetch queue (8086 BIU style) with flush redirect.
// Optional PFQ_STATS_EN adds saturating stat_bytes / stat_flushes counters.
module prefetch_queue #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DEPTH  = 6
) (
  input  logic clk,
  input  logic rst,
`ifdef PFQ_STATS_EN
  output logic [15:0] stat_bytes,
  output logic [15:0] stat_flushes,
`endif
  prefetch_queue_if.master bus
);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DROP = 2'd2
  } state_e;

  state_e            state_q;
  logic              mem_req_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [ADDR_W-1:0] fetch_q;
  logic [PTR_W-1:0]  rd_q, rd_d;
  logic [PTR_W-1:0]  wr_q, wr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              q_valid_q;
  logic [7:0]        buf_q [DEPTH];

  logic pop;
  logic push;
  logic can_req;

  // A flush overrides both queue ports; only a live REQ ack carries real data.
  assign pop     = bus.q_pop && q_valid_q && !bus.flush;
  assign push    = (state_q == ST_REQ) && bus.mem_ack && !bus.flush;
  assign can_req = !bus.flush && ((32'(count_q) + 32'(pop)) < DEPTH);

  always_comb begin
    rd_d    = rd_q;
    wr_d    = wr_q;
    count_d = count_q;
    if (bus.flush) begin
      rd_d    = '0;
      wr_d    = '0;
      count_d = '0;
    end else begin
      if (pop) begin
        rd_d = (rd_q == PTR_LAST) ? '0 : rd_q + PTR_W'(1);
      end
      if (push) begin
        wr_d = (wr_q == PTR_LAST) ? '0 : wr_q + PTR_W'(1);
      end
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // Byte storage needs no reset: q_byte is masked while the queue is empty.
  always_ff @(posedge clk) begin
    if (rst && push) begin
      buf_q[wr_q] <= bus.mem_rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      mem_req_q  <= 1'b0;
      mem_addr_q <= '0;
      fetch_q    <= '0;
      rd_q       <= '0;
      wr_q       <= '0;
      count_q    <= '0;
      q_valid_q  <= 1'b0;
    end else begin
      rd_q      <= rd_d;
      wr_q      <= wr_d;
      count_q   <= count_d;
      q_valid_q <= (count_d != '0);
      case (state_q)
        ST_IDLE: begin
          if (can_req) begin
            mem_req_q  <= 1'b1;
            mem_addr_q <= fetch_q;
            state_q    <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (bus.mem_ack) begin
            mem_req_q <= 1'b0;
            state_q   <= ST_IDLE;
            fetch_q   <= fetch_q + ADDR_W'(1);
          end else if (bus.flush) begin
            state_q <= ST_DROP;
          end
        end
        ST_DROP: begin
          // RAM still owes us a cycle; hold the old request and discard its data.
          if (bus.mem_ack) begin
            mem_req_q <= 1'b0;
            state_q   <= ST_IDLE;
          end
        end
        default: begin
          mem_req_q <= 1'b0;
          state_q   <= ST_IDLE;
        end
      endcase
      if (bus.flush) begin
        fetch_q <= bus.flush_addr;
      end
    end
  end

  assign bus.mem_req  = mem_req_q;
  assign bus.mem_addr = mem_addr_q;
  assign bus.q_valid  = q_valid_q;
  assign bus.q_count  = count_q;
  assign bus.q_byte   = q_valid_q ? buf_q[rd_q] : 8'h00;

`ifdef PFQ_STATS_EN
  logic [15:0] stat_bytes_q;
  logic [15:0] stat_flushes_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      stat_bytes_q   <= '0;
      stat_flushes_q <= '0;
    end else begin
      if (push && (stat_bytes_q != 16'hFFFF)) begin
        stat_bytes_q <= stat_bytes_q + 16'd1;
      end
      if (bus.flush && (stat_flushes_q != 16'hFFFF)) begin
        stat_flushes_q <= stat_flushes_q + 16'd1;
      end
    end
  end

  assign stat_bytes   = stat_bytes_q;
  assign stat_flushes = stat_flushes_q;
`endif
endmodule

// File: tb/tb_prefetch_queue.sv
// Bench for prefetch_queue: directed scenarios plus a randomized run against a
// byte-queue reference model. Build with PFQ_STATS_EN to also check the counters.
module tb_prefetch_queue;
  localparam int unsigned ADDR_W = 16;
  localparam int unsigned DEPTH  = 6;
  localparam int unsigned CNT_W  = $clog2(DEPTH + 1);

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  prefetch_queue_if #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) bus ();

`ifdef PFQ_STATS_EN
  logic [15:0] stat_bytes;
  logic [15:0] stat_flushes;
`endif

  prefetch_queue #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst          (rst),
`ifdef PFQ_STATS_EN
    .stat_bytes   (stat_bytes),
    .stat_flushes (stat_flushes),
`endif
    .bus          (bus.master)
  );

  // Reference model: the bytes the CPU should see, in order, and where fetching resumes.
  logic [7:0]        q[$];
  logic [ADDR_W-1:0] exp_addr;
  bit                drop;
  int                age;
  int                ack_delay;
  bit                stray_ack;
  bit                req_rose;
  int                exp_bytes;
  int                exp_flushes;
  int                pass_cnt;
  int                total_cnt;

  function automatic logic [7:0] ram(input logic [ADDR_W-1:0] a);
    return a[7:0] + 8'h10;
  endfunction

  // One clock: answer the RAM, then apply the edge's effect to the model.
  task automatic tick();
    logic s_rst, s_flush, s_pop, s_req, s_ack;
    logic [ADDR_W-1:0] s_faddr;
    if (bus.mem_req) bus.mem_ack = (age >= ack_delay);
    else             bus.mem_ack = stray_ack;
    bus.mem_rdata = bus.mem_req ? ram(bus.mem_addr) : 8'hEE;
    s_rst = rst; s_flush = bus.flush; s_pop = bus.q_pop;
    s_req = bus.mem_req; s_ack = bus.mem_ack; s_faddr = bus.flush_addr;
    @(posedge clk);
    #1;
    age = (s_req && !s_ack) ? age + 1 : 0;
    if (!s_rst) begin
      q.delete(); drop = 0; exp_addr = '0; age = 0;
      exp_bytes = 0; exp_flushes = 0;
    end else if (s_flush) begin
      q.delete(); exp_addr = s_faddr; exp_flushes++;
      if (s_req) drop = !s_ack;
    end else begin
      if (s_pop && q.size() != 0) void'(q.pop_front());
      if (s_req && s_ack) begin
        if (drop) drop = 0;
        else begin
          q.push_back(ram(exp_addr));
          exp_addr = exp_addr + ADDR_W'(1);
          exp_bytes++;
        end
      end
    end
    req_rose = bus.mem_req && !s_req;
  endtask

  task automatic test_reset();
    rst = 1'b0; bus.flush = 1'b0; bus.flush_addr = '0; bus.q_pop = 1'b0;
    bus.mem_ack = 1'b0; bus.mem_rdata = '0; stray_ack = 0; ack_delay = 1;
    tick(); tick();
    total_cnt++; if (bus.mem_req !== 1'b0) $display("FAIL reset_req: got %b expected 0", bus.mem_req); else pass_cnt++;
    total_cnt++; if (bus.mem_addr !== '0) $display("FAIL reset_addr: got %h expected 0000", bus.mem_addr); else pass_cnt++;
    total_cnt++; if (bus.q_valid !== 1'b0) $display("FAIL reset_valid: got %b expected 0", bus.q_valid); else pass_cnt++;
    total_cnt++; if (bus.q_count !== '0) $display("FAIL reset_count: got %0d expected 0", bus.q_count); else pass_cnt++;
    total_cnt++; if (bus.q_byte !== 8'h00) $display("FAIL reset_byte: got %h expected 00", bus.q_byte); else pass_cnt++;
  endtask

  task automatic test_reset_fill();
    int n = 0;
    rst = 1'b1;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (req_rose) begin
        total_cnt++; if (bus.mem_addr !== ADDR_W'(n)) $display("FAIL fill_addr: got %h expected %h", bus.mem_addr, ADDR_W'(n)); else pass_cnt++;
        n++;
      end
      total_cnt++; if (bus.q_count !== CNT_W'(q.size())) $display("FAIL fill_count: got %0d expected %0d", bus.q_count, q.size()); else pass_cnt++;
    end
    total_cnt++; if (n != 6) $display("FAIL fill_requests: got %0d expected 6", n); else pass_cnt++;
    total_cnt++; if (bus.q_count !== CNT_W'(6)) $display("FAIL fill_full: got %0d expected 6", bus.q_count); else pass_cnt++;
    total_cnt++; if (bus.q_byte !== 8'h10) $display("FAIL fill_byte: got %h expected 10", bus.q_byte); else pass_cnt++;
    total_cnt++; if (bus.mem_req !== 1'b0) $display("FAIL fill_idle: got %b expected 0", bus.mem_req); else pass_cnt++;
  endtask

  task automatic test_full_pop();
    int i;
    bus.q_pop = 1'b1; tick(); bus.q_pop = 1'b0;
    total_cnt++; if (bus.q_byte !== 8'h11) $display("FAIL pop_byte: got %h expected 11", bus.q_byte); else pass_cnt++;
    total_cnt++; if (bus.q_count !== CNT_W'(5)) $display("FAIL pop_count: got %0d expected 5", bus.q_count); else pass_cnt++;
    i = 0;
    do begin tick(); i++; end while (!req_rose && i < 10);
    total_cnt++; if (!req_rose || bus.mem_addr !== 16'h0006) $display("FAIL pop_refetch: got req=%b addr=%h expected addr 0006", bus.mem_req, bus.mem_addr); else pass_cnt++;
    i = 0;
    while (bus.q_count != CNT_W'(6) && i < 10) begin tick(); i++; end
    total_cnt++; if (bus.q_count !== CNT_W'(6)) $display("FAIL pop_refill: got %0d expected 6", bus.q_count); else pass_cnt++;
  endtask

  task automatic test_flush_idle();
    int i;
    total_cnt++; if (bus.mem_req !== 1'b0) $display("FAIL fidle_pre: got req %b expected 0", bus.mem_req); else pass_cnt++;
    bus.flush = 1'b1; bus.flush_addr = 16'h0200; tick(); bus.flush = 1'b0;
    total_cnt++; if (bus.q_valid !== 1'b0) $display("FAIL fidle_valid: got %b expected 0", bus.q_valid); else pass_cnt++;
    total_cnt++; if (bus.mem_req !== 1'b0) $display("FAIL fidle_early_req: got %b expected 0", bus.mem_req); else pass_cnt++;
    i = 0;
    do begin tick(); i++; end while (!req_rose && i < 10);
    total_cnt++; if (!req_rose || bus.mem_addr !== 16'h0200) $display("FAIL fidle_addr: got %h expected 0200", bus.mem_addr); else pass_cnt++;
    i = 0;
    while (!bus.q_valid && i < 10) begin tick(); i++; end
    total_cnt++; if (bus.q_valid !== 1'b1 || bus.q_byte !== 8'h10) $display("FAIL fidle_byte: got %h valid %b expected 10", bus.q_byte, bus.q_valid); else pass_cnt++;
  endtask

  task automatic test_latency();
    int i = 0;
    while (!(bus.q_count == CNT_W'(DEPTH) && !bus.mem_req) && i < 60) begin tick(); i++; end
    ack_delay = 0;
    bus.flush = 1'b1; bus.flush_addr = 16'h1234; tick(); bus.flush = 1'b0;
    total_cnt++; if (bus.mem_req !== 1'b0 || bus.q_valid !== 1'b0) $display("FAIL lat_flush: got req %b valid %b expected 0 0", bus.mem_req, bus.q_valid); else pass_cnt++;
    tick();
    total_cnt++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== 16'h1234) $display("FAIL lat_req: got req %b addr %h expected 1 1234", bus.mem_req, bus.mem_addr); else pass_cnt++;
    tick();
    total_cnt++; if (bus.q_valid !== 1'b1 || bus.q_byte !== 8'h44) $display("FAIL lat_byte: got valid %b byte %h expected 1 44", bus.q_valid, bus.q_byte); else pass_cnt++;
    tick();
    total_cnt++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== 16'h1235) $display("FAIL lat_next: got req %b addr %h expected 1 1235", bus.mem_req, bus.mem_addr); else pass_cnt++;
    tick();
    total_cnt++; if (bus.q_count !== CNT_W'(2)) $display("FAIL lat_rate: got %0d expected 2", bus.q_count); else pass_cnt++;
  endtask

  task automatic test_flush_inflight();
    int i = 0;
    int hold = 0;
    ack_delay = 3;
    bus.flush = 1'b1; bus.flush_addr = 16'h0000; tick(); bus.flush = 1'b0;
    do begin tick(); i++; end while (!(req_rose && bus.mem_addr == 16'h0003) && i < 80);
    total_cnt++; if (!req_rose || bus.mem_addr !== 16'h0003) $display("FAIL ffly_setup: got addr %h expected 0003", bus.mem_addr); else pass_cnt++;
    bus.flush = 1'b1; bus.flush_addr = 16'h0040; tick(); bus.flush = 1'b0;
    while (bus.mem_req && hold < 10) begin
      total_cnt++; if (bus.mem_addr !== 16'h0003) $display("FAIL ffly_hold: got %h expected 0003", bus.mem_addr); else pass_cnt++;
      tick(); hold++;
    end
    total_cnt++; if (bus.mem_req !== 1'b0) $display("FAIL ffly_ack: got req %b expected 0 after ack", bus.mem_req); else pass_cnt++;
    total_cnt++; if (bus.q_count !== '0) $display("FAIL ffly_discard: got %0d expected 0", bus.q_count); else pass_cnt++;
    i = 0;
    do begin tick(); i++; end while (!req_rose && i < 10);
    total_cnt++; if (!req_rose || bus.mem_addr !== 16'h0040) $display("FAIL ffly_addr: got %h expected 0040", bus.mem_addr); else pass_cnt++;
    i = 0;
    while (!bus.q_valid && i < 10) begin tick(); i++; end
    total_cnt++; if (bus.q_valid !== 1'b1 || bus.q_byte !== 8'h50) $display("FAIL ffly_byte: got %h expected 50", bus.q_byte); else pass_cnt++;
  endtask

  task automatic test_wrap_simul();
    logic [ADDR_W-1:0] seq [3];
    int i;
    int n;
    seq[0] = 16'hFFFE; seq[1] = 16'hFFFF; seq[2] = 16'h0000;
    ack_delay = 1;
    bus.flush = 1'b1; bus.flush_addr = 16'hFFFE; tick(); bus.flush = 1'b0;
    for (int k = 0; k < 3; k++) begin
      i = 0;
      do begin tick(); i++; end while (!req_rose && i < 20);
      total_cnt++; if (!req_rose || bus.mem_addr !== seq[k]) $display("FAIL wrap_addr%0d: got %h expected %h", k, bus.mem_addr, seq[k]); else pass_cnt++;
    end
    i = 0;
    while (!(bus.mem_req && age >= ack_delay && q.size() != 0) && i < 20) begin tick(); i++; end
    n = q.size();
    bus.q_pop = 1'b1; tick(); bus.q_pop = 1'b0;
    total_cnt++; if (i >= 20 || bus.q_count !== CNT_W'(n)) $display("FAIL simul_count: got %0d expected %0d", bus.q_count, n); else pass_cnt++;
    total_cnt++; if (bus.q_byte !== q[0]) $display("FAIL simul_byte: got %h expected %h", bus.q_byte, q[0]); else pass_cnt++;
  endtask

  task automatic test_random();
    for (int c = 0; c < 2000; c++) begin
      bus.flush      = ($urandom_range(0, 39) == 0);
      bus.flush_addr = ADDR_W'($urandom);
      bus.q_pop      = 1'($urandom_range(0, 1));
      stray_ack      = ($urandom_range(0, 3) == 0);
      if (!bus.mem_req) ack_delay = $urandom_range(0, 3);
      tick();
      if (req_rose) begin
        total_cnt++; if (bus.mem_addr !== exp_addr) $display("FAIL rnd_addr: got %h expected %h", bus.mem_addr, exp_addr); else pass_cnt++;
      end
      total_cnt++; if (bus.q_count !== CNT_W'(q.size())) $display("FAIL rnd_count: got %0d expected %0d", bus.q_count, q.size()); else pass_cnt++;
      total_cnt++; if (bus.q_valid !== (q.size() != 0)) $display("FAIL rnd_valid: got %b expected %b", bus.q_valid, q.size() != 0); else pass_cnt++;
      if (q.size() != 0) begin
        total_cnt++; if (bus.q_byte !== q[0]) $display("FAIL rnd_byte: got %h expected %h", bus.q_byte, q[0]); else pass_cnt++;
      end
    end
    bus.flush = 1'b0; bus.q_pop = 1'b0; stray_ack = 0;
`ifdef PFQ_STATS_EN
    total_cnt++; if (stat_bytes !== 16'(exp_bytes)) $display("FAIL stat_bytes: got %0d expected %0d", stat_bytes, exp_bytes); else pass_cnt++;
    total_cnt++; if (stat_flushes !== 16'(exp_flushes)) $display("FAIL stat_flushes: got %0d expected %0d", stat_flushes, exp_flushes); else pass_cnt++;
`endif
  endtask

  task automatic test_reset_mid();
    int i = 0;
    ack_delay = 3;
    while (!bus.mem_req && i < 20) begin tick(); i++; end
    total_cnt++; if (bus.mem_req !== 1'b1) $display("FAIL rmid_setup: got req %b expected 1", bus.mem_req); else pass_cnt++;
    rst = 1'b0; tick(); rst = 1'b1;
    total_cnt++; if (bus.mem_req !== 1'b0 || bus.mem_addr !== '0) $display("FAIL rmid_req: got req %b addr %h expected 0 0000", bus.mem_req, bus.mem_addr); else pass_cnt++;
    total_cnt++; if (bus.q_valid !== 1'b0 || bus.q_count !== '0 || bus.q_byte !== 8'h00) $display("FAIL rmid_queue: got valid %b count %0d byte %h expected 0 0 00", bus.q_valid, bus.q_count, bus.q_byte); else pass_cnt++;
`ifdef PFQ_STATS_EN
    total_cnt++; if (stat_bytes !== 16'h0 || stat_flushes !== 16'h0) $display("FAIL rmid_stats: got %0d %0d expected 0 0", stat_bytes, stat_flushes); else pass_cnt++;
`endif
    stray_ack = 1; tick(); stray_ack = 0;
    total_cnt++; if (bus.q_count !== '0) $display("FAIL rmid_late_ack: got %0d expected 0", bus.q_count); else pass_cnt++;
    total_cnt++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== 16'h0000) $display("FAIL rmid_restart: got req %b addr %h expected 1 0000", bus.mem_req, bus.mem_addr); else pass_cnt++;
    i = 0;
    while (!bus.q_valid && i < 10) begin tick(); i++; end
    total_cnt++; if (bus.q_byte !== 8'h10) $display("FAIL rmid_byte: got %h expected 10", bus.q_byte); else pass_cnt++;
  endtask

  initial begin
    pass_cnt = 0; total_cnt = 0; age = 0; drop = 0; exp_addr = '0;
    exp_bytes = 0; exp_flushes = 0; req_rose = 0;
    test_reset();
    test_reset_fill();
    test_full_pop();
    test_flush_idle();
    test_latency();
    test_flush_inflight();
    test_wrap_simul();
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
